// File: rtl/aibcr3_txdat_pkg.sv
//------------------------------------------------------------------------------
// Module  : aibcr3_txdat_pkg
// Brief   : Shared state encoding and PRBS7 constants for the TX data serializer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package aibcr3_txdat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PRBS  = 2'd2
    } txdat_state_t;

    localparam logic [6:0] PRBS7_SEED  = 7'h7F;
    localparam int         PRBS7_TAP_A = 6;
    localparam int         PRBS7_TAP_B = 5;

    // Advances x^7+x^6+1 by two bits; returns {next_state, b1, b0}.
    function automatic logic [8:0] prbs7_step2(input logic [6:0] s);
        logic       b0;
        logic       b1;
        logic [6:0] s1;
        logic [6:0] s2;
        b0 = s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B];
        s1 = {s[5:0], b0};
        b1 = s1[PRBS7_TAP_A] ^ s1[PRBS7_TAP_B];
        s2 = {s1[5:0], b1};
        return {s2, b1, b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aibcr3_txdat_fifo.sv
//------------------------------------------------------------------------------
// Module  : aibcr3_txdat_fifo
// Brief   : Two-entry word FIFO in front of the TX serializer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module aibcr3_txdat_fifo #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [WORD_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty
);

    logic [WORD_W-1:0] r_mem_q [0:1];
    logic [WORD_W-1:0] w_mem_d [0:1];
    logic              r_wptr_q, w_wptr_d;
    logic              r_rptr_q, w_rptr_d;
    logic [1:0]        r_cnt_q,  w_cnt_d;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_cnt_q == 2'd2);
    assign o_empty   = (r_cnt_q == 2'd0);
    assign o_rdata   = r_mem_q[r_rptr_q];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_comb begin
        w_mem_d  = r_mem_q;
        w_wptr_d = r_wptr_q ^ w_do_push;
        w_rptr_d = r_rptr_q ^ w_do_pop;
        w_cnt_d  = r_cnt_q;
        if (w_do_push) begin
            w_mem_d[r_wptr_q] = i_wdata;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   w_cnt_d = r_cnt_q + 2'd1;
            2'b01:   w_cnt_d = r_cnt_q - 2'd1;
            default: w_cnt_d = r_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_q[0] <= '0;
            r_mem_q[1] <= '0;
            r_wptr_q   <= 1'b0;
            r_rptr_q   <= 1'b0;
            r_cnt_q    <= 2'd0;
        end else begin
            r_mem_q    <= w_mem_d;
            r_wptr_q   <= w_wptr_d;
            r_rptr_q   <= w_rptr_d;
            r_cnt_q    <= w_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/aibcr3_txdat_ser.sv
//------------------------------------------------------------------------------
// Module  : aibcr3_txdat_ser
// Brief   : Word-to-bit-pair serializer feeding the DDR TX stage, with PRBS7 mode.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module aibcr3_txdat_ser
    import aibcr3_txdat_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              ilaunch_clk,
    input  logic              irstb,
    input  logic              ser_en,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              prbs_en,
    input  logic              idle_dat,
    output logic              idat0,
    output logic              idat1,
    output logic              busy,
    output logic [7:0]        underflow_cnt
);

    localparam int              NPAIRS    = WORD_W / 2;
    localparam int              PAIR_W    = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NPAIRS - 1);

    txdat_state_t      r_state_q, w_state_d;
    logic [WORD_W-1:0] r_shift_q, w_shift_d;
    logic [PAIR_W-1:0] r_pair_q,  w_pair_d;
    logic [6:0]        r_prbs_q,  w_prbs_d;
    logic [7:0]        r_ufl_q,   w_ufl_d;
    logic              r_idat0_q, w_idat0_d;
    logic              r_idat1_q, w_idat1_d;

    logic              w_push;
    logic              w_pop;
    logic [WORD_W-1:0] w_fifo_rdata;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_can_load;

    assign in_ready      = ~w_fifo_full & (r_state_q != ST_PRBS) & irstb;
    assign busy          = (r_state_q != ST_IDLE);
    assign idat0         = r_idat0_q;
    assign idat1         = r_idat1_q;
    assign underflow_cnt = r_ufl_q;
    assign w_push        = in_valid & in_ready;
    assign w_can_load    = ser_en & ~w_fifo_empty;

    aibcr3_txdat_fifo #(
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk     (ilaunch_clk),
        .rst_n   (irstb),
        .i_push  (w_push),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_shift_d = r_shift_q;
        w_pair_d  = r_pair_q;
        w_prbs_d  = r_prbs_q;
        w_ufl_d   = r_ufl_q;
        w_idat0_d = idle_dat;
        w_idat1_d = idle_dat;
        w_pop     = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (prbs_en) begin
                    w_state_d = ST_PRBS;
                    {w_prbs_d, w_idat1_d, w_idat0_d} = prbs7_step2(PRBS7_SEED);
                end else if (w_can_load) begin
                    w_state_d = ST_SHIFT;
                    w_pop     = 1'b1;
                    w_idat0_d = w_fifo_rdata[0];
                    w_idat1_d = w_fifo_rdata[1];
                    w_shift_d = w_fifo_rdata >> 2;
                    w_pair_d  = '0;
                end
            end
            ST_SHIFT: begin
                // r_pair_q is the index of the pair currently on the outputs.
                if (r_pair_q != LAST_PAIR) begin
                    w_idat0_d = r_shift_q[0];
                    w_idat1_d = r_shift_q[1];
                    w_shift_d = r_shift_q >> 2;
                    w_pair_d  = r_pair_q + 1'b1;
                end else if (w_can_load) begin
                    w_pop     = 1'b1;
                    w_idat0_d = w_fifo_rdata[0];
                    w_idat1_d = w_fifo_rdata[1];
                    w_shift_d = w_fifo_rdata >> 2;
                    w_pair_d  = '0;
                end else begin
                    w_state_d = ST_IDLE;
                    if (ser_en && (r_ufl_q != 8'hFF)) begin
                        w_ufl_d = r_ufl_q + 8'd1;
                    end
                end
            end
            ST_PRBS: begin
                if (prbs_en) begin
                    {w_prbs_d, w_idat1_d, w_idat0_d} = prbs7_step2(r_prbs_q);
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ilaunch_clk or negedge irstb) begin
        if (!irstb) begin
            r_state_q <= ST_IDLE;
            r_shift_q <= '0;
            r_pair_q  <= '0;
            r_prbs_q  <= PRBS7_SEED;
            r_ufl_q   <= 8'd0;
            r_idat0_q <= 1'b0;
            r_idat1_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_shift_q <= w_shift_d;
            r_pair_q  <= w_pair_d;
            r_prbs_q  <= w_prbs_d;
            r_ufl_q   <= w_ufl_d;
            r_idat0_q <= w_idat0_d;
            r_idat1_q <= w_idat1_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/aibcr3_txdat_ser.md
AIBCR3_TXDAT_SER -- requirements
Module: aibcr3_txdat_ser

Interface
REQ-001 SHALL have parameter WORD_W, default 8, parallel word width; must be even and at least 4.
REQ-002 SHALL have port ilaunch_clk, input, 1: the single clock, the same launch clock that drives the downstream DDR TX flops.
REQ-003 SHALL have port irstb, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port ser_en, input, 1: enables word serialization.
REQ-005 SHALL have port in_data, input, WORD_W: parallel TX word.
REQ-006 SHALL have port in_valid, input, 1: in_data valid.
REQ-007 SHALL have port in_ready, output, 1: word accepted on an edge where in_valid=1 and in_ready=1.
REQ-008 SHALL have port prbs_en, input, 1: PRBS7 test-pattern request.
REQ-009 SHALL have port idle_dat, input, 1: line value driven when idle.
REQ-010 SHALL have port idat0, output, 1: even (first-launched) bit to the DDR TX stage.
REQ-011 SHALL have port idat1, output, 1: odd bit to the DDR TX stage.
REQ-012 SHALL have port busy, output, 1: high when state is not IDLE.
REQ-013 SHALL have port underflow_cnt, output, 8: saturating underflow count.

Function
REQ-014 SHALL buffer words in a 2-entry FIFO; in_ready = FIFO not full AND state != PRBS AND irstb=1.
REQ-015 SHALL implement states IDLE, SHIFT, PRBS; busy = (state != IDLE).
REQ-016 IDLE -> PRBS SHALL occur when prbs_en=1; prbs_en takes priority over FIFO data.
REQ-017 IDLE -> SHIFT SHALL occur when prbs_en=0, ser_en=1 and the FIFO is non-empty, popping one word into the shifter on the same edge.
REQ-018 Serialization order SHALL be LSB-first: pair k drives idat0=word[2k], idat1=word[2k+1], for k=0..WORD_W/2-1, one pair per cycle.
REQ-019 idat0/idat1 SHALL be registered; pair 0 SHALL be visible after the edge that pops the word (1 cycle after acceptance when the FIFO was empty and state was IDLE).
REQ-020 On the last-pair cycle, if ser_en=1 and the FIFO is non-empty, the block SHALL pop the next word and keep SHIFT with no bubble.
REQ-021 On the last-pair cycle, if ser_en=1 and the FIFO is empty, the block SHALL go to IDLE and increment underflow_cnt, saturating at 255.
REQ-022 If ser_en drops mid-word, the block SHALL finish the current word, then go to IDLE without counting underflow; FIFO contents SHALL be retained.
REQ-023 In IDLE, idat0 and idat1 SHALL both equal idle_dat, registered with 1-cycle latency.
REQ-024 The PRBS7 generator SHALL use polynomial x^7+x^6+1 on a 7-bit state s, seeded 7'h7F on reset and on each PRBS entry.
REQ-025 PRBS7 SHALL produce 2 bits per cycle: b0=s[6]^s[5], s'={s[5:0],b0}; b1=s'[6]^s'[5], s''={s'[5:0],b1}; idat0=b0, idat1=b1.
REQ-026 PRBS -> IDLE SHALL occur on the first edge with prbs_en=0.
REQ-027 A simultaneous FIFO push and pop SHALL be legal at any occupancy; a push when full SHALL NOT occur because in_ready=0.

Reset
REQ-028 irstb=0 SHALL asynchronously set: state=IDLE, FIFO empty (contents discarded), shifter and pair counter cleared, idat0=idat1=0, underflow_cnt=0, PRBS state=7'h7F, in_ready=0.
REQ-029 Reset asserted mid-word SHALL abandon the word; output SHALL follow idle_dat from the first edge after release.

Structure
REQ-030 Shared package aibcr3_txdat_pkg SHALL hold the state encoding, PRBS7 seed, and tap positions.
REQ-031 The FIFO SHALL be sub-module aibcr3_txdat_fifo (2-entry, WORD_W parameterised, async active-low reset).

Verification
REQ-032 Reset, then push 8'hB4 with ser_en=1 -> pairs (idat0,idat1) = (0,0),(1,0),(1,1),(0,1) on consecutive cycles, then IDLE, underflow_cnt=1.
REQ-033 Three back-to-back words 8'hFF,8'h00,8'hA5 with ser_en=1 -> 12 contiguous pairs with no gap, in_ready low while the FIFO is full, underflow_cnt=1 only after the third word.
REQ-034 Drop ser_en during pair 1 with a second word queued -> current word completes, busy falls, underflow_cnt unchanged, queued word is sent after ser_en returns.
REQ-035 prbs_en=1 from IDLE -> first four pairs (0,0),(0,0),(0,0),(1,0), in_ready=0; prbs_en=0 -> IDLE next edge.
REQ-036 Assert irstb=0 mid-word with FIFO full -> outputs 0 and underflow_cnt=0 immediately; after release, nothing is transmitted and idat follows idle_dat=1.
REQ-037 Force 256 underflows -> underflow_cnt holds at 255.
